// File: rtl/gps_pkg.sv
// Shared definitions for the GPS serial front end: UART receiver states,
// NMEA character constants and small helpers used by the receiver and parser.
package gps_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_G      = 8'h47;
    localparam logic [7:0] ASCII_P      = 8'h50;
    localparam logic [7:0] ASCII_R      = 8'h52;
    localparam logic [7:0] ASCII_M      = 8'h4D;
    localparam logic [7:0] ASCII_C      = 8'h43;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;

    // Rounded clock divisor producing one tick per oversample period.
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, held at phase
// zero while clr is high so the first tick lands a fixed time after clr drops.
module baud_tick_gen
    import gps_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state is only ever written with non-blocking
    // assignments so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/gps_uart_rx.sv
// 8N1 UART receiver for the GPS serial line: 2-FF synchroniser, 16x
// oversampling, 3-sample majority vote, glitch rejection and framing check.
module gps_uart_rx
    import gps_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [3:0] S_V7 = 4'd7;
    localparam logic [3:0] S_V8 = 4'd8;
    localparam logic [3:0] S_V9 = 4'd9;

    uart_state_t state;
    logic        sync1;
    logic        rxs;
    logic        rxs_prev;
    logic [3:0]  s;
    logic [2:0]  n;
    logic        v7;
    logic        v8;
    logic [7:0]  shreg;
    logic        tick;
    logic        clr;
    logic        vote;
    logic        mid_bit;

    assign clr     = (state == ST_IDLE);
    assign vote    = majority3(v7, v8, rxs);
    assign mid_bit = tick && (s == S_V9);

    baud_tick_gen #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            rxs_prev  <= 1'b1;
            state     <= ST_IDLE;
            s         <= '0;
            n         <= '0;
            v7        <= 1'b1;
            v8        <= 1'b1;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync1     <= rx_in;
            rxs       <= sync1;
            rxs_prev  <= rxs;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (tick) begin
                s <= s + 4'd1;
                if (s == S_V7) v7 <= rxs;
                if (s == S_V8) v8 <= rxs;
            end

            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    s    <= '0;
                    n    <= '0;
                    if (rxs_prev && !rxs) begin
                        state <= ST_START;
                        busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (mid_bit) begin
                        if (!vote) begin
                            state <= ST_DATA;
                            n     <= '0;
                        end else begin
                            // Start bit did not hold to mid-bit: a glitch.
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                ST_DATA: begin
                    if (mid_bit) begin
                        shreg <= {vote, shreg[7:1]};
                        if (n == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            n <= n + 3'd1;
                        end
                    end
                end

                ST_STOP: begin
                    if (mid_bit) begin
                        if (vote) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end
                end

                ST_BREAK: begin
                    // A held-low line reports one error, then waits for idle.
                    if (rxs) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
